// File: rtl/id_front_pkg.sv
// rtl/id_front_pkg.sv - shared decode constants and types for the ID front end
package id_front_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // R-type function codes
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  // Tuse / Tnew share one width
  localparam int T_W = 2;
  typedef logic [T_W-1:0] t_val_t;

  // An unused source field gets the largest Tuse; since a Tnew can never
  // exceed it, the "Tuse < Tnew" test is always false and it never stalls.
  localparam t_val_t TUSE_NONE = 2'd3;

  // Next-PC select presented to IF
  typedef enum logic [1:0] {
    JC_PC4   = 2'b00,
    JC_NADD  = 2'b01,
    JC_SPLIT = 2'b10,
    JC_RD1   = 2'b11
  } jump_ctrl_e;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/id_front_stall_ctrl.sv
// rtl/id_front_stall_ctrl.sv - Tuse decode and Tnew comparison producing the ID stall
module id_front_stall_ctrl
  import id_front_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic [4:0] e_a3,
  input  logic [4:0] m_a3,
  input  t_val_t     e_tnew,
  input  t_val_t     m_tnew,
  output logic       stall
);

  t_val_t tuse_rs;
  t_val_t tuse_rt;

  // A source hazards when a later-stage producer will not have its value ready
  // by the time this instruction needs it; $0 is never a real dependency.
  function automatic logic src_hazard(input logic [4:0] r, input t_val_t tuse,
                                      input logic [4:0] ea3, input t_val_t etn,
                                      input logic [4:0] ma3, input t_val_t mtn);
    return (r != 5'd0) &&
           (((r == ea3) && (tuse < etn)) || ((r == ma3) && (tuse < mtn)));
  endfunction

  // Decode when each source field is consumed; anything unsupported uses nothing
  always_comb begin
    tuse_rs = TUSE_NONE;
    tuse_rt = TUSE_NONE;
    case (opcode)
      OP_RTYPE: begin
        if (funct == FN_ADDU || funct == FN_SUBU) begin
          tuse_rs = 2'd1;
          tuse_rt = 2'd1;
        end else if (funct == FN_JR) begin
          tuse_rs = 2'd0;
        end
      end
      OP_ORI, OP_LW: tuse_rs = 2'd1;
      OP_SW: begin
        tuse_rs = 2'd1;
        tuse_rt = 2'd2;
      end
      OP_BEQ: begin
        tuse_rs = 2'd0;
        tuse_rt = 2'd0;
      end
      default: ;
    endcase
  end

  // Either source against either producer stage is enough to stall
  always_comb begin
    stall = src_hazard(rs, tuse_rs, e_a3, e_tnew, m_a3, m_tnew) ||
            src_hazard(rt, tuse_rt, e_a3, e_tnew, m_a3, m_tnew);
  end

endmodule

// File: rtl/id_front.sv
// rtl/id_front.sv - IF/ID register, branch/jump targets, next-PC select and stall control
module id_front
  import id_front_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] F_Instr,
  input  logic [31:0] F_PC4,
  input  logic [31:0] F_PC,
  input  logic [31:0] RD1,
  input  logic [31:0] RD2,
  input  logic [4:0]  E_A3,
  input  logic [4:0]  M_A3,
  input  logic [1:0]  E_Tnew,
  input  logic [1:0]  M_Tnew,
  output logic [31:0] D_Instr,
  output logic [31:0] D_PC4,
  output logic [31:0] D_PC,
  output logic [4:0]  D_rs,
  output logic [4:0]  D_rt,
  output logic [31:0] Nadder,
  output logic [31:0] splitter,
  output logic [1:0]  JumpCtrl,
  output logic        pc_en,
  output logic        flush_e,
  output logic [31:0] stall_cnt
);

  logic       stall;
  logic [5:0] opcode;
  logic [5:0] funct;
  jump_ctrl_e jump_sel;

  assign opcode = D_Instr[31:26];
  assign funct  = D_Instr[5:0];
  assign D_rs   = D_Instr[25:21];
  assign D_rt   = D_Instr[20:16];

  id_front_stall_ctrl u_stall_ctrl (
    .opcode (opcode),
    .funct  (funct),
    .rs     (D_rs),
    .rt     (D_rt),
    .e_a3   (E_A3),
    .m_a3   (M_A3),
    .e_tnew (E_Tnew),
    .m_tnew (M_Tnew),
    .stall  (stall)
  );

  // IF/ID register: holds while stalled; the delay slot is never flushed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      D_Instr <= 32'd0;
      D_PC4   <= RESET_PC + 32'd4;
      D_PC    <= RESET_PC;
    end else if (!stall) begin
      D_Instr <= F_Instr;
      D_PC4   <= F_PC4;
      D_PC    <= F_PC;
    end
  end

  // Count stalled cycles since reset, wrapping naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= 32'd0;
    end else if (stall) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  // Branch and jump targets, both relative to the delay-slot PC
  always_comb begin
    Nadder   = D_PC4 + {{14{D_Instr[15]}}, D_Instr[15:0], 2'b00};
    splitter = {D_PC4[31:28], D_Instr[25:0], 2'b00};
  end

  // Next-PC select; a stalled instruction must not redirect fetch yet
  always_comb begin
    jump_sel = JC_PC4;
    if (!stall) begin
      case (opcode)
        OP_BEQ:       jump_sel = (RD1 == RD2) ? JC_NADD : JC_PC4;
        OP_J, OP_JAL: jump_sel = JC_SPLIT;
        OP_RTYPE:     jump_sel = (funct == FN_JR) ? JC_RD1 : JC_PC4;
        default:      jump_sel = JC_PC4;
      endcase
    end
  end

  // Stall freezes fetch and injects a bubble into EX
  always_comb begin
    JumpCtrl = jump_sel;
    pc_en    = !stall;
    flush_e  = stall;
  end

endmodule

// File: tb/tb_id_front.sv
// tb/tb_id_front.sv - self-checking bench for id_front
module tb_id_front;

  logic        clk;
  logic        reset;
  logic [31:0] F_Instr, F_PC4, F_PC, RD1, RD2;
  logic [4:0]  E_A3, M_A3;
  logic [1:0]  E_Tnew, M_Tnew;
  logic [31:0] D_Instr, D_PC4, D_PC, Nadder, splitter, stall_cnt;
  logic [4:0]  D_rs, D_rt;
  logic [1:0]  JumpCtrl;
  logic        pc_en, flush_e;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [31:0] pc;
  } d_exp_t;

  d_exp_t sb[$];
  d_exp_t e;

  id_front dut (
    .clk       (clk),
    .reset     (reset),
    .F_Instr   (F_Instr),
    .F_PC4     (F_PC4),
    .F_PC      (F_PC),
    .RD1       (RD1),
    .RD2       (RD2),
    .E_A3      (E_A3),
    .M_A3      (M_A3),
    .E_Tnew    (E_Tnew),
    .M_Tnew    (M_Tnew),
    .D_Instr   (D_Instr),
    .D_PC4     (D_PC4),
    .D_PC      (D_PC),
    .D_rs      (D_rs),
    .D_rt      (D_rt),
    .Nadder    (Nadder),
    .splitter  (splitter),
    .JumpCtrl  (JumpCtrl),
    .pc_en     (pc_en),
    .flush_e   (flush_e),
    .stall_cnt (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  task automatic clear_hazards();
    E_A3 = 5'd0; M_A3 = 5'd0; E_Tnew = 2'd0; M_Tnew = 2'd0;
  endtask

  // Drive an IF bundle with no hazards and clock it into ID; record what ID must hold
  task automatic load(input logic [31:0] instr, input logic [31:0] pc4, input logic [31:0] pc);
    clear_hazards();
    F_Instr = instr; F_PC4 = pc4; F_PC = pc;
    sb.push_back('{instr, pc4, pc});
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_hazards();
    F_Instr = 32'h1234_5678; F_PC4 = 32'hAAAA_0004; F_PC = 32'hAAAA_0000;
    RD1 = 32'd0; RD2 = 32'd1;
    #2;
    checks++; if (D_Instr !== 32'd0) begin errors++; $display("FAIL reset_instr: got %h want %h", D_Instr, 32'd0); end
    checks++; if (D_PC4 !== 32'h3004) begin errors++; $display("FAIL reset_pc4: got %h want %h", D_PC4, 32'h3004); end
    checks++; if (D_PC !== 32'h3000) begin errors++; $display("FAIL reset_pc: got %h want %h", D_PC, 32'h3000); end
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %h want 0", stall_cnt); end
    checks++; if (pc_en !== 1'b1 || flush_e !== 1'b0 || JumpCtrl !== 2'b00) begin
      errors++; $display("FAIL reset_ctrl: got pc_en=%b flush_e=%b JumpCtrl=%b want 1 0 00", pc_en, flush_e, JumpCtrl);
    end
    @(posedge clk); #1;
    checks++; if (D_Instr !== 32'd0) begin errors++; $display("FAIL reset_held: got %h want 0", D_Instr); end
    reset = 1'b0;
  endtask

  task automatic test_load();
    load(i_type(6'h0d, 5'd0, 5'd1, 16'd5), 32'h3004, 32'h3000);
    e = sb.pop_front();
    checks++; if (D_Instr !== e.instr) begin errors++; $display("FAIL load_instr: got %h want %h", D_Instr, e.instr); end
    checks++; if (D_PC4 !== e.pc4) begin errors++; $display("FAIL load_pc4: got %h want %h", D_PC4, e.pc4); end
    checks++; if (D_PC !== e.pc) begin errors++; $display("FAIL load_pc: got %h want %h", D_PC, e.pc); end
    checks++; if (D_rs !== 5'd0 || D_rt !== 5'd1) begin errors++; $display("FAIL load_fields: got rs=%0d rt=%0d want 0 1", D_rs, D_rt); end
    checks++; if (JumpCtrl !== 2'b00 || pc_en !== 1'b1) begin
      errors++; $display("FAIL load_ctrl: got JumpCtrl=%b pc_en=%b want 00 1", JumpCtrl, pc_en);
    end
    // back-to-back loads advance every cycle
    load(i_type(6'h0d, 5'd1, 5'd2, 16'h00FF), 32'h3008, 32'h3004);
    load(i_type(6'h0f, 5'd0, 5'd3, 16'h1234), 32'h300C, 32'h3008);
    e = sb.pop_front();
    e = sb.pop_front();
    checks++; if (D_Instr !== e.instr || D_PC !== e.pc) begin
      errors++; $display("FAIL back_to_back: got %h/%h want %h/%h", D_Instr, D_PC, e.instr, e.pc);
    end
  endtask

  task automatic test_branch();
    load(i_type(6'h04, 5'd1, 5'd2, 16'd3), 32'h3004, 32'h3000);
    e = sb.pop_front();
    checks++; if (D_Instr !== e.instr) begin errors++; $display("FAIL beq_load: got %h want %h", D_Instr, e.instr); end
    RD1 = 32'd7; RD2 = 32'd7; #1;
    checks++; if (Nadder !== 32'h3010) begin errors++; $display("FAIL beq_target: got %h want %h", Nadder, 32'h3010); end
    checks++; if (JumpCtrl !== 2'b01) begin errors++; $display("FAIL beq_taken: got %b want 01", JumpCtrl); end
    RD2 = 32'd8; #1;
    checks++; if (JumpCtrl !== 2'b00) begin errors++; $display("FAIL beq_not_taken: got %b want 00", JumpCtrl); end
    // negative offset
    load(i_type(6'h04, 5'd0, 5'd0, 16'hFFFF), 32'h3004, 32'h3000);
    e = sb.pop_front();
    checks++; if (Nadder !== 32'h3000) begin errors++; $display("FAIL beq_neg: got %h want %h", Nadder, 32'h3000); end
    // target wraps past 2^32
    load(i_type(6'h04, 5'd0, 5'd0, 16'd2), 32'hFFFF_FFFC, 32'hFFFF_FFF8);
    e = sb.pop_front();
    checks++; if (Nadder !== 32'h0000_0004) begin errors++; $display("FAIL beq_wrap: got %h want %h", Nadder, 32'h4); end
  endtask

  task automatic test_jump();
    load({6'h02, 26'h000_0C00}, 32'h3008, 32'h3004);
    e = sb.pop_front();
    checks++; if (splitter !== 32'h3000) begin errors++; $display("FAIL j_target: got %h want %h", splitter, 32'h3000); end
    checks++; if (JumpCtrl !== 2'b10) begin errors++; $display("FAIL j_ctrl: got %b want 10", JumpCtrl); end
    load({6'h03, 26'h3FF_FFFF}, 32'hA000_0010, 32'hA000_000C);
    e = sb.pop_front();
    checks++; if (splitter !== 32'hAFFF_FFFC || JumpCtrl !== 2'b10) begin
      errors++; $display("FAIL jal: got %h/%b want %h/10", splitter, JumpCtrl, 32'hAFFF_FFFC);
    end
    load(r_type(5'd31, 5'd0, 5'd0, 6'h08), 32'h3010, 32'h300C);
    e = sb.pop_front();
    RD1 = 32'h3100; #1;
    checks++; if (JumpCtrl !== 2'b11) begin errors++; $display("FAIL jr_ctrl: got %b want 11", JumpCtrl); end
    // unsupported opcode (bne) decodes as nop
    load(i_type(6'h05, 5'd5, 5'd6, 16'd4), 32'h3014, 32'h3010);
    e = sb.pop_front();
    E_A3 = 5'd5; E_Tnew = 2'd3; #1;
    checks++; if (JumpCtrl !== 2'b00 || pc_en !== 1'b1) begin
      errors++; $display("FAIL unsupported: got JumpCtrl=%b pc_en=%b want 00 1", JumpCtrl, pc_en);
    end
  endtask

  task automatic test_stall();
    do_reset();
    load(r_type(5'd5, 5'd0, 5'd6, 6'h21), 32'h3104, 32'h3100);
    e = sb.pop_front();
    sb.push_back(e);
    E_A3 = 5'd5; E_Tnew = 2'd2;
    F_Instr = 32'hDEAD_BEEF; F_PC4 = 32'h4444_4444; F_PC = 32'h4444_4440;
    #1;
    checks++; if (pc_en !== 1'b0 || flush_e !== 1'b1) begin
      errors++; $display("FAIL stall_ctrl: got pc_en=%b flush_e=%b want 0 1", pc_en, flush_e);
    end
    repeat (2) @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++; if (D_Instr !== e.instr || D_PC4 !== e.pc4 || D_PC !== e.pc) begin
      errors++; $display("FAIL stall_hold: got %h/%h/%h want %h/%h/%h", D_Instr, D_PC4, D_PC, e.instr, e.pc4, e.pc);
    end
    checks++; if (stall_cnt !== 32'd2) begin errors++; $display("FAIL stall_cnt: got %0d want 2", stall_cnt); end
    E_Tnew = 2'd1; #1;
    checks++; if (pc_en !== 1'b1 || flush_e !== 1'b0) begin
      errors++; $display("FAIL stall_release: got pc_en=%b flush_e=%b want 1 0", pc_en, flush_e);
    end
    // jr stalled: redirect suppressed
    load(r_type(5'd5, 5'd0, 5'd0, 6'h08), 32'h3108, 32'h3104);
    e = sb.pop_front();
    E_A3 = 5'd5; E_Tnew = 2'd1; RD1 = 32'h5000; #1;
    checks++; if (pc_en !== 1'b0 || JumpCtrl !== 2'b00) begin
      errors++; $display("FAIL jr_stall: got pc_en=%b JumpCtrl=%b want 0 00", pc_en, JumpCtrl);
    end
    // sw rt is needed late: Tnew 2 fine, Tnew 3 stalls
    load(i_type(6'h2b, 5'd0, 5'd5, 16'd0), 32'h310C, 32'h3108);
    e = sb.pop_front();
    E_A3 = 5'd5; E_Tnew = 2'd2; #1;
    checks++; if (pc_en !== 1'b1) begin errors++; $display("FAIL sw_rt_ok: got pc_en=%b want 1", pc_en); end
    E_Tnew = 2'd3; #1;
    checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL sw_rt_stall: got pc_en=%b want 0", pc_en); end
    // ori rt is a destination, not a source
    load(i_type(6'h0d, 5'd0, 5'd5, 16'd1), 32'h3110, 32'h310C);
    e = sb.pop_front();
    E_A3 = 5'd5; E_Tnew = 2'd3; #1;
    checks++; if (pc_en !== 1'b1) begin errors++; $display("FAIL ori_rt_unused: got pc_en=%b want 1", pc_en); end
    // $0 never hazards
    load(r_type(5'd0, 5'd0, 5'd7, 6'h23), 32'h3114, 32'h3110);
    e = sb.pop_front();
    E_A3 = 5'd0; E_Tnew = 2'd3; M_A3 = 5'd0; M_Tnew = 2'd3; #1;
    checks++; if (pc_en !== 1'b1) begin errors++; $display("FAIL zero_reg: got pc_en=%b want 1", pc_en); end
  endtask

  task automatic test_mem_hazard();
    load(i_type(6'h04, 5'd5, 5'd0, 16'd8), 32'h3204, 32'h3200);
    e = sb.pop_front();
    M_A3 = 5'd5; M_Tnew = 2'd1; #1;
    checks++; if (pc_en !== 1'b0 || flush_e !== 1'b1) begin
      errors++; $display("FAIL beq_mem_stall: got pc_en=%b flush_e=%b want 0 1", pc_en, flush_e);
    end
    M_A3 = 5'd0; E_A3 = 5'd0; #1;
    checks++; if (pc_en !== 1'b1) begin errors++; $display("FAIL beq_no_stall: got pc_en=%b want 1", pc_en); end
    // both stages name rs: EX alone is fine, MEM alone requires a stall
    E_A3 = 5'd5; E_Tnew = 2'd0; M_A3 = 5'd5; M_Tnew = 2'd1; #1;
    checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL both_match: got pc_en=%b want 0", pc_en); end
    M_Tnew = 2'd0; #1;
    checks++; if (pc_en !== 1'b1) begin errors++; $display("FAIL both_ready: got pc_en=%b want 1", pc_en); end
  endtask

  task automatic test_async_reset();
    load(r_type(5'd5, 5'd0, 5'd6, 6'h21), 32'h3304, 32'h3300);
    e = sb.pop_front();
    E_A3 = 5'd5; E_Tnew = 2'd2;
    @(posedge clk); #3;
    checks++; if (pc_en !== 1'b0 || stall_cnt === 32'd0) begin
      errors++; $display("FAIL pre_reset_stall: got pc_en=%b stall_cnt=%0d want 0 nonzero", pc_en, stall_cnt);
    end
    reset = 1'b1; #1;
    checks++; if (D_Instr !== 32'd0 || stall_cnt !== 32'd0) begin
      errors++; $display("FAIL async_reset: got D_Instr=%h stall_cnt=%0d want 0 0", D_Instr, stall_cnt);
    end
    checks++; if (pc_en !== 1'b1 || flush_e !== 1'b0) begin
      errors++; $display("FAIL async_release: got pc_en=%b flush_e=%b want 1 0", pc_en, flush_e);
    end
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    clear_hazards();
    F_Instr = 32'd0; F_PC4 = 32'd0; F_PC = 32'd0; RD1 = 32'd0; RD2 = 32'd0;
    test_reset();
    test_load();
    test_branch();
    test_jump();
    test_stall();
    test_mem_hazard();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
